// File: rtl/tune_pkg.sv
// Shared types, widths and the note table for the tune player.
// TUNE_PLAYER_REST_EN selects a rest note (period 0) as tune 2; otherwise tune 2 is a short tone.
package tune_pkg;

  localparam int PERIOD_W  = 15;
  localparam int DUR_W     = 24;
  localparam int ROM_TUNES = 4;
  localparam int ROM_NOTES = 8;
  localparam int TUNE_IW   = $clog2(ROM_TUNES);
  localparam int NOTE_IW   = $clog2(ROM_NOTES);

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    duration;
    logic                last;
  } note_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Padding entries sit after a last-flagged note and are never reached.
  localparam note_t PAD   = note_t'{15'd2, 24'd2, 1'b1};
  localparam note_t BEEP2 = note_t'{15'd2, 24'd2, 1'b0};

  localparam note_t TUNE_ROM [ROM_TUNES][ROM_NOTES] = '{
    '{note_t'{15'd6, 24'd12, 1'b0}, note_t'{15'd10, 24'd20, 1'b0},
      note_t'{15'd4, 24'd8, 1'b1}, PAD, PAD, PAD, PAD, PAD},
    '{note_t'{15'd8, 24'd32, 1'b0}, note_t'{15'd4, 24'd16, 1'b1},
      PAD, PAD, PAD, PAD, PAD, PAD},
`ifdef TUNE_PLAYER_REST_EN
    '{note_t'{15'd0, 24'd32, 1'b1}, PAD, PAD, PAD, PAD, PAD, PAD, PAD},
`else
    '{note_t'{15'd6, 24'd6, 1'b1}, PAD, PAD, PAD, PAD, PAD, PAD, PAD},
`endif
    // No last flag anywhere: exercises the end-of-table stop.
    '{BEEP2, BEEP2, BEEP2, BEEP2, BEEP2, BEEP2, BEEP2, BEEP2}
  };

  function automatic note_t rom_note(input logic [TUNE_IW-1:0] tune,
                                     input logic [NOTE_IW-1:0] idx);
    return TUNE_ROM[tune][idx];
  endfunction

endpackage

// File: rtl/tune_player_note_gen.sv
// Square-wave generator: period counter 0..period-1 and complementary buzzer drive.
// TUNE_PLAYER_REST_EN makes period 0 a silent rest; otherwise period 0 drives piezo_n statically.
module note_gen
  import tune_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                piezo_o,
  output logic                piezo_n_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (clr_i || (period_i == '0) || (cnt_q == period_i - PERIOD_W'(1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    piezo_o   = 1'b0;
    piezo_n_o = 1'b0;
    if (en_i) begin
      if (period_i == '0) begin
`ifdef TUNE_PLAYER_REST_EN
        piezo_n_o = 1'b0;
`else
        piezo_n_o = 1'b1;
`endif
      end else begin
        piezo_o   = (cnt_q < (period_i >> 1));
        piezo_n_o = ~piezo_o;
      end
    end
  end

endmodule

// File: rtl/tune_player.sv
// Tune sequencer: IDLE/PLAY FSM, duration counter and note stepping over tune_pkg::TUNE_ROM.
// Build option TUNE_PLAYER_REST_EN (handled in note_gen/tune_pkg) turns period-0 notes into rests.
module tune_player
  import tune_pkg::*;
#(
  parameter int FAST_SIM  = 1,
  parameter int NUM_TUNES = 2,
  parameter int MAX_NOTES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  input  logic                         stop,
  input  logic [$clog2(NUM_TUNES)-1:0] tune_sel,
  input  logic                         loop,
  output logic                         piezo,
  output logic                         piezo_n,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_NOTES)-1:0] note_idx
);

  localparam int TSW = $clog2(NUM_TUNES);
  localparam int NIW = $clog2(MAX_NOTES);
  localparam logic [DUR_W:0] STEP = (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);

  state_t         state_q, state_d;
  logic [TSW-1:0] tune_q, tune_d;
  logic [NIW-1:0] idx_q, idx_d;
  logic [DUR_W:0] dur_q, dur_d;

  note_t          cur_note;
  logic [DUR_W:0] dur_sum;
  logic           note_end;
  logic           is_last;
  logic           gen_clr;
  logic           done_c;

  assign cur_note = rom_note(TUNE_IW'(tune_q), NOTE_IW'(idx_q));
  assign dur_sum  = dur_q + STEP;
  assign note_end = (dur_sum >= {1'b0, cur_note.duration});
  // The final table slot ends the tune even without its last flag.
  assign is_last  = cur_note.last || (idx_q == NIW'(MAX_NOTES - 1));

  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    gen_clr = 1'b1;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go && !stop) begin
          state_d = PLAY;
          tune_d  = tune_sel;
          idx_d   = '0;
          dur_d   = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
          dur_d   = '0;
        end else if (note_end) begin
          dur_d = '0;
          if (!is_last) begin
            idx_d = idx_q + NIW'(1);
          end else if (loop) begin
            idx_d = '0;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            done_c  = 1'b1;
          end
        end else begin
          dur_d   = dur_sum;
          gen_clr = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dur_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tune_q  <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      tune_q  <= tune_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
    end
  end

  note_gen u_note_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == PLAY),
    .clr_i     (gen_clr),
    .period_i  (cur_note.period),
    .piezo_o   (piezo),
    .piezo_n_o (piezo_n)
  );

  assign busy     = (state_q == PLAY);
  assign done     = done_c;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tune_player.sv
// Scoreboard bench: expected output runs {busy,done,idx,piezo,piezo_n} x length are queued by
// the stimulus; a negedge monitor collapses DUT outputs into runs and compares them in order.
module tb_tune_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       go_s, stop_s, loop_s;
  logic [1:0] sel_s;
  logic       piezo_s, piezo_n_s, busy_s, done_s;
  logic [2:0] idx_s;
  logic       go_f, stop_f, loop_f;
  logic [0:0] sel_f;
  logic       piezo_f, piezo_n_f, busy_f, done_f;
  logic [2:0] idx_f;

  tune_player #(.FAST_SIM(0), .NUM_TUNES(4), .MAX_NOTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .go(go_s), .stop(stop_s), .tune_sel(sel_s), .loop(loop_s),
    .piezo(piezo_s), .piezo_n(piezo_n_s), .busy(busy_s), .done(done_s), .note_idx(idx_s)
  );

  tune_player #(.FAST_SIM(1), .NUM_TUNES(2), .MAX_NOTES(8)) dut_fast (
    .clk(clk), .rst_n(rst_n), .go(go_f), .stop(stop_f), .tune_sel(sel_f), .loop(loop_f),
    .piezo(piezo_f), .piezo_n(piezo_n_f), .busy(busy_f), .done(done_f), .note_idx(idx_f)
  );

  typedef struct {
    logic [13:0] vec;
    int          len;
  } run_t;

  run_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   run_no = 0;

  function automatic logic [6:0] v(input logic b, input logic d, input logic [2:0] i,
                                   input logic p, input logic pn);
    return {b, d, i, p, pn};
  endfunction

  task automatic push_run(input logic fast, input logic [6:0] vec, input int n);
    run_t r;
    r.vec = fast ? {7'd0, vec} : {vec, 7'd0};
    r.len = n;
    exp_q.push_back(r);
  endtask

  // Expected runs for one tone of even period lasting ncyc cycles.
  task automatic push_note(input logic fast, input logic [2:0] idx, input int period,
                           input int ncyc, input logic done_end);
    logic [6:0] cur, nv;
    logic       hi;
    int         len;
    cur = '0;
    len = 0;
    for (int c = 0; c < ncyc; c++) begin
      hi = ((c % period) < (period / 2));
      nv = v(1'b1, done_end && (c == ncyc - 1), idx, hi, !hi);
      if (len != 0 && nv != cur) begin
        push_run(fast, cur, len);
        len = 0;
      end
      cur = nv;
      len++;
    end
    push_run(fast, cur, len);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end else begin
      $display("[TB] ok %s = %0h", name, got);
    end
  endtask

  task automatic start_s(input logic [1:0] sel, input logic lp);
    @(posedge clk);
    #1 sel_s = sel; loop_s = lp; go_s = 1'b1;
    @(posedge clk);
    #1 go_s = 1'b0;
  endtask

  // Monitor: collapse sampled outputs into runs; idle (all-zero) runs are not compared.
  initial begin
    logic [13:0] prev_vec, cur_vec;
    int          run_len;
    run_t        r;
    prev_vec = '0;
    run_len  = 0;
    forever begin
      @(negedge clk);
      cur_vec = {busy_s, done_s, idx_s, piezo_s, piezo_n_s,
                 busy_f, done_f, idx_f, piezo_f, piezo_n_f};
      if (cur_vec === prev_vec) begin
        run_len++;
      end else begin
        if (prev_vec !== '0) begin
          tests_run++;
          run_no++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL run%0d unexpected: got vec=%h len=%0d, expected none",
                     run_no, prev_vec, run_len);
          end else begin
            r = exp_q.pop_front();
            if (r.vec !== prev_vec || r.len != run_len) begin
              tests_failed++;
              $display("FAIL run%0d: got vec=%h len=%0d, expected vec=%h len=%0d",
                       run_no, prev_vec, run_len, r.vec, r.len);
            end else begin
              $display("[TB] run%0d vec=%h len=%0d ok", run_no, prev_vec, run_len);
            end
          end
        end
        prev_vec = cur_vec;
        run_len  = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    go_s = 0; stop_s = 0; loop_s = 0; sel_s = '0;
    go_f = 0; stop_f = 0; loop_f = 0; sel_f = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state_slow", {24'd0, busy_s, done_s, idx_s, piezo_s, piezo_n_s}, 32'd0);
    check_val("reset_state_fast", {24'd0, busy_f, done_f, idx_f, piezo_f, piezo_n_f}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Tune 1, no loop: 32 cycles of 4/4, 16 cycles of 2/2, done in the final cycle.
    push_note(0, 3'd0, 8, 32, 0);
    push_note(0, 3'd1, 4, 16, 1);
    start_s(2'd1, 1'b0);
    repeat (60) @(posedge clk);
    #1 check_val("idle_after_tune1", {27'd0, busy_s, piezo_s, piezo_n_s, done_s, |idx_s}, 32'd0);

    // Tune 1 looping; loop dropped during the second pass of note 1.
    push_note(0, 3'd0, 8, 32, 0);
    push_note(0, 3'd1, 4, 16, 0);
    push_note(0, 3'd0, 8, 32, 0);
    push_note(0, 3'd1, 4, 16, 1);
    start_s(2'd1, 1'b1);
    repeat (85) @(posedge clk);
    #1 loop_s = 1'b0;
    repeat (20) @(posedge clk);

    // Stop in cycle 10 of note 0.
    push_run(0, v(1, 0, 3'd0, 1, 0), 4);
    push_run(0, v(1, 0, 3'd0, 0, 1), 4);
    push_run(0, v(1, 0, 3'd0, 1, 0), 2);
    start_s(2'd1, 1'b0);
    repeat (9) @(posedge clk);
    #1 stop_s = 1'b1;
    @(posedge clk);
    #1 stop_s = 1'b0;
    check_val("stop_to_idle", {27'd0, busy_s, piezo_s, piezo_n_s, done_s, |idx_s}, 32'd0);
    @(posedge clk);
    #1 go_s = 1'b1; stop_s = 1'b1;
    @(posedge clk);
    #1 go_s = 1'b0; stop_s = 1'b0;
    check_val("go_stop_same_cycle", {31'd0, busy_s}, 32'd0);
    repeat (5) @(posedge clk);

    // Asynchronous reset mid note 1, then a clean restart from note 0.
    push_note(0, 3'd0, 8, 32, 0);
    push_note(0, 3'd1, 4, 8, 0);
    start_s(2'd1, 1'b0);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_val("reset_async", {24'd0, busy_s, done_s, idx_s, piezo_s, piezo_n_s}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_note(0, 3'd0, 8, 32, 0);
    push_note(0, 3'd1, 4, 16, 1);
    start_s(2'd1, 1'b0);
    repeat (55) @(posedge clk);

    // Tune 3 has no last flags: must stop after index 7.
    for (int i = 0; i < 8; i++) push_note(0, 3'(i), 2, 2, i == 7);
    start_s(2'd3, 1'b0);
    repeat (25) @(posedge clk);

    // Tune 0: three notes of different periods.
    push_note(0, 3'd0, 6, 12, 0);
    push_note(0, 3'd1, 10, 20, 0);
    push_note(0, 3'd2, 4, 8, 1);
    start_s(2'd0, 1'b0);
    repeat (50) @(posedge clk);

    // Tune 2: rest when enabled, otherwise a plain 6-cycle tone.
`ifdef TUNE_PLAYER_REST_EN
    push_run(0, v(1, 0, 3'd0, 0, 0), 31);
    push_run(0, v(1, 1, 3'd0, 0, 0), 1);
`else
    push_note(0, 3'd0, 6, 6, 1);
`endif
    start_s(2'd2, 1'b0);
    repeat (40) @(posedge clk);

    // Fast step on the second instance: note 0 lasts 2 cycles, note 1 one cycle with done.
    push_note(1, 3'd0, 8, 2, 0);
    push_note(1, 3'd1, 4, 1, 1);
    @(posedge clk);
    #1 sel_f = 1'b1; go_f = 1'b1;
    @(posedge clk);
    #1 go_f = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_val("fast_idle_after", {30'd0, busy_f, piezo_n_f}, 32'd0);

    repeat (3) @(posedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
